// File: rtl/sr_exc_pkg.sv
// Shared types, constants and the SR excitation function for sr_excitation_driver.
package sr_exc_pkg;

  typedef enum logic [1:0] {
    UNK   = 2'd0,  // model state unknown: next pop forces the flip-flop
    TRACK = 2'd1,  // model tracks the flip-flop: pops apply the excitation table
    HALT  = 2'd2   // stopped after a mismatch until err_clr
  } state_e;

  typedef struct packed {
    logic s;
    logic r;
  } sr_t;

  localparam sr_t SR_HOLD = 2'b00;
  localparam sr_t SR_SET  = 2'b10;
  localparam sr_t SR_RST  = 2'b01;

  // Excitation table with don't-cares resolved to 0, so s=r=1 cannot occur.
  function automatic sr_t sr_excite(input logic q_m, input logic tgt);
    if (q_m == tgt) return SR_HOLD;
    else if (tgt)   return SR_SET;
    else            return SR_RST;
  endfunction

endpackage

// File: rtl/bit_fifo.sv
// Synchronous 1-bit FIFO; pointers carry one extra wrap bit to tell full from empty.
module bit_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_bit,
  input  logic pop,
  output logic pop_bit,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] mem_q, mem_d;
  logic             do_push, do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_bit = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer and storage values.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_bit;
      wr_ptr_d                = wr_ptr_q + (AW + 1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage register.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the pointers alone say which entries are valid.
    mem_q <= mem_d;
  end

endmodule

// File: rtl/sr_excitation_driver.sv
// Turns a stream of wanted q bits into s/r drive for an external SR flip-flop
// and checks the flip-flop's q feedback two cycles after each drive.
module sr_excitation_driver
  import sr_exc_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 8,
  parameter bit HALT_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  output logic             s,
  output logic             r,
  input  logic             q_fb,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  state_e           state_q, state_d;
  logic             q_m_q, q_m_d;
  sr_t              sr_q, sr_d;
  logic             chk1_vld_q, chk1_vld_d, chk1_bit_q, chk1_bit_d;
  logic             chk2_vld_q, chk2_vld_d, chk2_bit_q, chk2_bit_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic fifo_full, fifo_empty, fifo_bit;
  logic push, pop, mismatch, halt_now;

  assign tgt_ready = !fifo_full;
  assign push      = tgt_valid && tgt_ready;
  assign mismatch  = chk2_vld_q && (q_fb != chk2_bit_q);
  // A mismatch that will halt also blocks the pop of the same cycle, so no drive follows the error.
  assign halt_now  = HALT_ON_ERR && mismatch && !err_clr;
  assign pop       = !fifo_empty && (state_q != HALT) && !halt_now;

  assign s       = sr_q.s;
  assign r       = sr_q.r;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign busy    = !fifo_empty || chk1_vld_q || chk2_vld_q;

  bit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_bit (tgt_bit),
    .pop      (pop),
    .pop_bit  (fifo_bit),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // FSM next state, model q and s/r drive; a mismatch overrides the pop transition.
  always_comb begin
    state_d = state_q;
    q_m_d   = q_m_q;
    sr_d    = SR_HOLD;
    if (pop) begin
      q_m_d = fifo_bit;
      case (state_q)
        UNK: begin
          sr_d    = fifo_bit ? SR_SET : SR_RST;
          state_d = TRACK;
        end
        TRACK:   sr_d = sr_excite(q_m_q, fifo_bit);
        default: sr_d = SR_HOLD;
      endcase
    end
    if (mismatch) begin
      state_d = halt_now ? HALT : UNK;
    end else if (err_clr && (state_q == HALT)) begin
      state_d = UNK;
    end
  end

  // Two-stage expected-bit pipeline and sticky error / saturating counter; clear wins.
  always_comb begin
    chk1_vld_d = pop;
    chk1_bit_d = fifo_bit;
    chk2_vld_d = chk1_vld_q;
    chk2_bit_d = chk1_bit_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    if (err_clr) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end else if (mismatch) begin
      err_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // State, drive, pipeline and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= UNK;
      q_m_q      <= 1'b0;
      sr_q       <= SR_HOLD;
      chk1_vld_q <= 1'b0;
      chk1_bit_q <= 1'b0;
      chk2_vld_q <= 1'b0;
      chk2_bit_q <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      q_m_q      <= q_m_d;
      sr_q       <= sr_d;
      chk1_vld_q <= chk1_vld_d;
      chk1_bit_q <= chk1_bit_d;
      chk2_vld_q <= chk2_vld_d;
      chk2_bit_q <= chk2_bit_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule
